// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the mem_io_slave bus-slave model.
package mem_io_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_DECODE = 5'b00010,
    ST_WAIT   = 5'b00100,
    ST_XFER   = 5'b01000,
    ST_FINAL  = 5'b10000
  } State_t;

  function automatic logic [LANE_W-1:0] lane_merge(input logic [LANE_W-1:0] old_b,
                                                   input logic [LANE_W-1:0] new_b,
                                                   input logic              en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_io_array.sv
// Word array with per-lane write enables and combinational read; optional clear on reset.
module mem_io_array
  import mem_io_pkg::*;
#(
  parameter int WORDS    = 16,
  parameter int DATA_W   = 16,
  parameter int AW       = 4,
  parameter bit RESET_EN = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [DATA_W/LANE_W-1:0] be_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem_q [WORDS];

  generate
    if (RESET_EN) begin : g_rst
      // Register file: cleared by reset, lane-masked writes.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int w = 0; w < WORDS; w++) mem_q[w] <= '0;
        end else if (we_i) begin
          for (int l = 0; l < LANES; l++)
            mem_q[addr_i][l*LANE_W +: LANE_W] <=
              lane_merge(mem_q[addr_i][l*LANE_W +: LANE_W], wdata_i[l*LANE_W +: LANE_W], be_i[l]);
        end
      end
    end else begin : g_norst
      // Bulk storage: contents survive reset, lane-masked writes.
      always_ff @(posedge clk_i) begin
        if (we_i) begin
          for (int l = 0; l < LANES; l++)
            mem_q[addr_i][l*LANE_W +: LANE_W] <=
              lane_merge(mem_q[addr_i][l*LANE_W +: LANE_W], wdata_i[l*LANE_W +: LANE_W], be_i[l]);
        end
      end
    end
  endgenerate

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_io_slave.sv
// Bus-slave model: ALE-decoded memory/IO spaces, programmable wait states, lane masking.
// Define MEMIO_ACCESS_CNT_EN to add the RdCount/WrCount access counters.
module mem_io_slave
  import mem_io_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int MEM_WORDS   = 4096,
  parameter int IO_WORDS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ALE,
  input  logic                     IOM,
  input  logic [ADDR_W-1:0]        Address,
  input  logic [DATA_W/LANE_W-1:0] BE_n,
  input  logic                     RD_n,
  input  logic                     WR_n,
  input  logic [DATA_W-1:0]        DataIn,
`ifdef MEMIO_ACCESS_CNT_EN
  output logic [15:0]              RdCount,
  output logic [15:0]              WrCount,
`endif
  output logic [DATA_W-1:0]        DataOut,
  output logic                     OE,
  output logic                     READY,
  output logic                     ERR
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int LSB   = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W = ADDR_W - LSB;
  localparam int MAW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int IAW   = (IO_WORDS > 1) ? $clog2(IO_WORDS) : 1;
  localparam logic [IDX_W:0] MEM_LIM = (IDX_W+1)'(MEM_WORDS);
  localparam logic [IDX_W:0] IO_LIM  = (IDX_W+1)'(IO_WORDS);
  localparam logic [3:0]     WS      = 4'(WAIT_STATES);

  State_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               iom_q, iom_d;
  logic               wr_q, wr_d;
  logic [LANES-1:0]   be_n_q, be_n_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               oe_q, oe_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic               in_range_s;
  logic               mem_we_s, io_we_s;
  logic [DATA_W-1:0]  mem_rdata_s, io_rdata_s, sel_rdata_s, masked_s;

  // Full word index is compared, so bits above the decoded range never alias.
  assign in_range_s  = iom_q ? ({1'b0, idx_q} < IO_LIM) : ({1'b0, idx_q} < MEM_LIM);
  assign sel_rdata_s = iom_q ? io_rdata_s : mem_rdata_s;

  mem_io_array #(.WORDS(MEM_WORDS), .DATA_W(DATA_W), .AW(MAW), .RESET_EN(1'b0)) u_mem (
    .clk_i(CLK), .rst_i(RESET), .we_i(mem_we_s), .be_i(~be_n_q),
    .addr_i(idx_q[MAW-1:0]), .wdata_i(DataIn), .rdata_o(mem_rdata_s)
  );

  mem_io_array #(.WORDS(IO_WORDS), .DATA_W(DATA_W), .AW(IAW), .RESET_EN(1'b1)) u_io (
    .clk_i(CLK), .rst_i(RESET), .we_i(io_we_s), .be_i(~be_n_q),
    .addr_i(idx_q[IAW-1:0]), .wdata_i(DataIn), .rdata_o(io_rdata_s)
  );

  // Disabled read lanes are forced to zero.
  always_comb begin
    masked_s = '0;
    for (int l = 0; l < LANES; l++)
      masked_s[l*LANE_W +: LANE_W] =
        lane_merge({LANE_W{1'b0}}, sel_rdata_s[l*LANE_W +: LANE_W], ~be_n_q[l]);
  end

  // Next-state and registered-output logic for the bus cycle FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    iom_d    = iom_q;
    wr_d     = wr_q;
    be_n_d   = be_n_q;
    cnt_d    = cnt_q;
    dout_d   = '0;
    oe_d     = 1'b0;
    err_d    = 1'b0;
    mem_we_s = 1'b0;
    io_we_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ALE) begin
          idx_d   = Address[ADDR_W-1:LSB];
          iom_d   = IOM;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (ALE) begin
          idx_d = Address[ADDR_W-1:LSB];
          iom_d = IOM;
        end else if (!RD_n && !WR_n) begin
          err_d   = 1'b1;
          state_d = ST_FINAL;
        end else if (!RD_n || !WR_n) begin
          wr_d    = !WR_n;
          be_n_d  = BE_n;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? ST_WAIT : ST_XFER;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_XFER: begin
        if (in_range_s) begin
          if (wr_q) begin
            mem_we_s = !iom_q;
            io_we_s  = iom_q;
          end else begin
            dout_d = masked_s;
            oe_d   = 1'b1;
          end
        end else begin
          err_d = 1'b1;
          if (!wr_q) begin
            dout_d = '1;
            oe_d   = 1'b1;
          end else begin
            oe_d = 1'b0;
          end
        end
        state_d = ST_FINAL;
      end
      ST_FINAL: begin
        if (RD_n && WR_n) state_d = ST_IDLE;
        else              state_d = ST_FINAL;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_WAIT);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      iom_q   <= 1'b0;
      wr_q    <= 1'b0;
      be_n_q  <= '1;
      cnt_q   <= 4'd0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      iom_q   <= iom_d;
      wr_q    <= wr_d;
      be_n_q  <= be_n_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign DataOut = dout_q;
  assign OE      = oe_q;
  assign READY   = ready_q;
  assign ERR     = err_q;

`ifdef MEMIO_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // In-range transfer counters, wrapping at 16 bits.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (state_q == ST_XFER && in_range_s) begin
      if (wr_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign RdCount = rd_cnt_q;
  assign WrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_io_slave.sv
// Directed self-checking bench: two instances (WAIT_STATES=1 and 3) share one bus.
module tb_mem_io_slave;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ALE = 1'b0, IOM = 1'b0, RD_n = 1'b1, WR_n = 1'b1;
  logic [19:0] Address = 20'h0;
  logic [1:0]  BE_n = 2'b11;
  logic [15:0] DataIn = 16'h0;
  logic [15:0] DataOut1, DataOut3;
  logic        OE1, OE3, READY1, READY3, ERR1, ERR3;
`ifdef MEMIO_ACCESS_CNT_EN
  logic [15:0] rd1, wr1, rd3, wr3;
`endif

  int passed = 0;
  int total  = 0;

  logic [15:0] d1, d3;
  bit          oe1, oe3, err1, err3;
  int          lat1, lat3, rl1, rl3;

  always #5 CLK = ~CLK;

  mem_io_slave #(.WAIT_STATES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .Address(Address), .BE_n(BE_n),
    .RD_n(RD_n), .WR_n(WR_n), .DataIn(DataIn),
`ifdef MEMIO_ACCESS_CNT_EN
    .RdCount(rd1), .WrCount(wr1),
`endif
    .DataOut(DataOut1), .OE(OE1), .READY(READY1), .ERR(ERR1));

  mem_io_slave #(.WAIT_STATES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .Address(Address), .BE_n(BE_n),
    .RD_n(RD_n), .WR_n(WR_n), .DataIn(DataIn),
`ifdef MEMIO_ACCESS_CNT_EN
    .RdCount(rd3), .WrCount(wr3),
`endif
    .DataOut(DataOut3), .OE(OE3), .READY(READY3), .ERR(ERR3));

  // mode: 0 = read, 1 = write, 2 = both strobes low
  task automatic bus_cycle(input bit iom, input logic [19:0] addr, input logic [1:0] be_n,
                           input int mode, input logic [15:0] wdata);
    d1 = 16'h0; d3 = 16'h0; oe1 = 1'b0; oe3 = 1'b0; err1 = 1'b0; err3 = 1'b0;
    lat1 = -1; lat3 = -1; rl1 = 0; rl3 = 0;
    @(posedge CLK); #1;
    ALE = 1'b1; IOM = iom; Address = addr;
    @(posedge CLK); #1;
    ALE = 1'b0; BE_n = be_n; DataIn = wdata;
    RD_n = (mode == 1); WR_n = (mode == 0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge CLK); #1;
      if (!READY1) rl1++;
      if (!READY3) rl3++;
      if (OE1 && lat1 < 0) begin lat1 = k - 1; d1 = DataOut1; end
      if (OE3 && lat3 < 0) begin lat3 = k - 1; d3 = DataOut3; end
      if (OE1) oe1 = 1'b1;
      if (OE3) oe3 = 1'b1;
      if (ERR1) err1 = 1'b1;
      if (ERR3) err3 = 1'b1;
    end
    RD_n = 1'b1; WR_n = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #3;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    total++; if (DataOut1 !== 16'h0) $display("FAIL reset_dout got %h want 0000", DataOut1); else passed++;
    total++; if (OE1 !== 1'b0) $display("FAIL reset_oe got %b want 0", OE1); else passed++;
    total++; if (READY1 !== 1'b1) $display("FAIL reset_ready got %b want 1", READY1); else passed++;
    total++; if (ERR1 !== 1'b0) $display("FAIL reset_err got %b want 0", ERR1); else passed++;
    total++; if (READY3 !== 1'b1) $display("FAIL reset_ready3 got %b want 1", READY3); else passed++;
    RESET = 1'b0;
  endtask

  task automatic test_mem_rw();
    bus_cycle(1'b0, 20'h00010, 2'b00, 1, 16'hBEEF);
    total++; if (err1 !== 1'b0) $display("FAIL wr_err got %b want 0", err1); else passed++;
    total++; if (oe1 !== 1'b0) $display("FAIL wr_oe got %b want 0", oe1); else passed++;
    total++; if (rl1 != 1) $display("FAIL wr_ready_low got %0d want 1", rl1); else passed++;
    bus_cycle(1'b0, 20'h00010, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'hBEEF) $display("FAIL rd_data got %h want BEEF", d1); else passed++;
    total++; if (lat1 != 2) $display("FAIL rd_latency got %0d want 2", lat1); else passed++;
    total++; if (rl1 != 1) $display("FAIL rd_ready_low got %0d want 1", rl1); else passed++;
    total++; if (err1 !== 1'b0) $display("FAIL rd_err got %b want 0", err1); else passed++;
  endtask

  task automatic test_lane_mask();
    bus_cycle(1'b0, 20'h00020, 2'b00, 1, 16'h1234);
    bus_cycle(1'b0, 20'h00020, 2'b10, 1, 16'hAA55);
    bus_cycle(1'b0, 20'h00020, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'h1255) $display("FAIL lane_merge got %h want 1255", d1); else passed++;
    bus_cycle(1'b0, 20'h00020, 2'b01, 0, 16'h0000);
    total++; if (d1 !== 16'h1200) $display("FAIL lane_rd_hi got %h want 1200", d1); else passed++;
    bus_cycle(1'b0, 20'h00020, 2'b11, 0, 16'h0000);
    total++; if (d1 !== 16'h0000 || oe1 !== 1'b1) $display("FAIL be_none_rd got %h oe %b want 0000 oe 1", d1, oe1); else passed++;
    bus_cycle(1'b0, 20'h00020, 2'b11, 1, 16'hFFFF);
    bus_cycle(1'b0, 20'h00020, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'h1255) $display("FAIL be_none_wr got %h want 1255", d1); else passed++;
  endtask

  task automatic test_io();
    bus_cycle(1'b1, 20'h0001E, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'h0000 || oe1 !== 1'b1 || err1 !== 1'b0) $display("FAIL io_reset_rd got %h oe %b err %b want 0000 1 0", d1, oe1, err1); else passed++;
    bus_cycle(1'b1, 20'h0001E, 2'b00, 1, 16'h5A5A);
    bus_cycle(1'b1, 20'h0001E, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'h5A5A) $display("FAIL io_rw got %h want 5A5A", d1); else passed++;
    bus_cycle(1'b1, 20'h00020, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'hFFFF || oe1 !== 1'b1 || err1 !== 1'b1) $display("FAIL io_oor got %h oe %b err %b want FFFF 1 1", d1, oe1, err1); else passed++;
  endtask

  task automatic test_double_strobe();
    bus_cycle(1'b0, 20'h00010, 2'b00, 2, 16'h0000);
    total++; if (err1 !== 1'b1) $display("FAIL dbl_err got %b want 1", err1); else passed++;
    total++; if (oe1 !== 1'b0) $display("FAIL dbl_oe got %b want 0", oe1); else passed++;
    bus_cycle(1'b0, 20'h00010, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'hBEEF) $display("FAIL dbl_mem got %h want BEEF", d1); else passed++;
  endtask

  task automatic test_boundary();
    bus_cycle(1'b0, 20'h01FFE, 2'b00, 1, 16'hC0DE);
    bus_cycle(1'b0, 20'h01FFE, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'hC0DE || err1 !== 1'b0) $display("FAIL last_word got %h err %b want C0DE 0", d1, err1); else passed++;
    bus_cycle(1'b0, 20'h02000, 2'b00, 1, 16'h1111);
    total++; if (err1 !== 1'b1 || oe1 !== 1'b0) $display("FAIL oor_wr got err %b oe %b want 1 0", err1, oe1); else passed++;
    bus_cycle(1'b0, 20'h02000, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'hFFFF || err1 !== 1'b1) $display("FAIL oor_rd got %h err %b want FFFF 1", d1, err1); else passed++;
    bus_cycle(1'b0, 20'h80010, 2'b00, 0, 16'h0000);
    total++; if (d1 !== 16'hFFFF || err1 !== 1'b1) $display("FAIL no_alias got %h err %b want FFFF 1", d1, err1); else passed++;
  endtask

  task automatic test_wait3();
    bus_cycle(1'b0, 20'h00010, 2'b00, 0, 16'h0000);
    total++; if (d3 !== 16'hBEEF) $display("FAIL ws3_data got %h want BEEF", d3); else passed++;
    total++; if (rl3 != 3) $display("FAIL ws3_ready_low got %0d want 3", rl3); else passed++;
    total++; if (lat3 != 4) $display("FAIL ws3_latency got %0d want 4", lat3); else passed++;
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    ALE = 1'b1; IOM = 1'b0; Address = 20'h00010;
    @(posedge CLK); #1;
    ALE = 1'b0; BE_n = 2'b00; DataIn = 16'h0BAD; WR_n = 1'b0;
    @(posedge CLK); #1;
    total++; if (READY3 !== 1'b0) $display("FAIL mid_in_wait got %b want 0", READY3); else passed++;
    #2 RESET = 1'b1;
    #1;
    total++; if (READY3 !== 1'b1 || READY1 !== 1'b1) $display("FAIL mid_async_ready got %b/%b want 1/1", READY1, READY3); else passed++;
    total++; if (OE3 !== 1'b0 || ERR3 !== 1'b0) $display("FAIL mid_async_out got oe %b err %b want 0 0", OE3, ERR3); else passed++;
    WR_n = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    bus_cycle(1'b0, 20'h00010, 2'b00, 0, 16'h0000);
    total++; if (d3 !== 16'hBEEF || d1 !== 16'hBEEF) $display("FAIL mid_discard got %h/%h want BEEF/BEEF", d1, d3); else passed++;
  endtask

`ifdef MEMIO_ACCESS_CNT_EN
  task automatic test_counters();
    pulse_reset();
    bus_cycle(1'b0, 20'h00040, 2'b00, 1, 16'h0001);
    bus_cycle(1'b0, 20'h00042, 2'b00, 1, 16'h0002);
    bus_cycle(1'b0, 20'h00044, 2'b00, 1, 16'h0003);
    bus_cycle(1'b0, 20'h00040, 2'b00, 0, 16'h0000);
    bus_cycle(1'b0, 20'h00042, 2'b00, 0, 16'h0000);
    bus_cycle(1'b0, 20'h02000, 2'b00, 0, 16'h0000);
    total++; if (wr1 !== 16'd3 || wr3 !== 16'd3) $display("FAIL wr_count got %0d/%0d want 3", wr1, wr3); else passed++;
    total++; if (rd1 !== 16'd2 || rd3 !== 16'd2) $display("FAIL rd_count got %0d/%0d want 2", rd1, rd3); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_mem_rw();
    test_lane_mask();
    test_io();
    test_double_strobe();
    test_boundary();
    test_wait3();
    test_reset_mid();
`ifdef MEMIO_ACCESS_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
